// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise-logic datapath: op-code values and the
// issuer's FSM state encoding.
package logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHAIN = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/logic_op_eval.sv
// Purely combinational bitwise evaluator: r = a OP b over N bits.
module logic_op_eval
  import logic_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] r
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves r unassigned (no latch).
    r = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/logic_chain_issuer.sv
// Sequenced front end to the logic op set: folds a chain of command beats into
// an accumulator and issues one backpressured result beat per chain.
module logic_chain_issuer
  import logic_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [N-1:0]  cmd_operand,
  input  logic          cmd_first,
  input  logic          cmd_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic [CW-1:0] res_count,
  output logic          res_err
);

  state_t        state, state_nxt;
  logic [N-1:0]  acc, acc_nxt, op_result;
  logic [CW-1:0] count, count_nxt;
  logic          err, err_nxt;
  logic          load_res;
  logic          beat;

  logic_op_eval #(.N(N)) u_op_eval (
    .a  (acc),
    .b  (cmd_operand),
    .op (cmd_op),
    .r  (op_result)
  );

  // Gated with rst_n so the block refuses beats while reset is held.
  assign cmd_ready = rst_n && (state != ST_RESP);
  assign res_valid = (state == ST_RESP);
  assign beat      = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    err_nxt   = err;
    load_res  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (beat) begin
          acc_nxt   = cmd_operand;
          count_nxt = CW'(1);
          err_nxt   = ~cmd_first;
          load_res  = cmd_last;
          state_nxt = cmd_last ? ST_RESP : ST_CHAIN;
        end
      end
      ST_CHAIN: begin
        if (beat) begin
          if (cmd_first) begin
            // Restart inside a chain reloads but marks the chain as violated.
            acc_nxt   = cmd_operand;
            count_nxt = CW'(1);
            err_nxt   = 1'b1;
          end else begin
            acc_nxt   = op_result;
            count_nxt = (count == '1) ? count : count + CW'(1);
          end
          load_res  = cmd_last;
          state_nxt = cmd_last ? ST_RESP : ST_CHAIN;
        end
      end
      ST_RESP: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      err       <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      res_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      err   <= err_nxt;
      if (load_res) begin
        res_data  <= acc_nxt;
        res_count <= count_nxt;
        res_err   <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_logic_chain_issuer.sv
// Self-checking bench for logic_chain_issuer: directed plan steps plus random
// chains checked against a per-chain fold model.
module tb_logic_chain_issuer;

  localparam int N  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_operand;
  logic          cmd_first;
  logic          cmd_last;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic [CW-1:0] res_count;
  logic          res_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] v;
    bit           first;
  } beat_t;

  beat_t chain_q[$];

  logic_chain_issuer #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .cmd_first   (cmd_first),
    .cmd_last    (cmd_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_count   (res_count),
    .res_err     (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-chain reference: the result comes from the last beat flagged first
  // (or the opening beat), folded left over the remaining beats.
  task automatic model_result(output logic [N-1:0] d, output int c, output bit e);
    int s = 0;
    e = !chain_q[0].first;
    for (int i = 1; i < chain_q.size(); i++)
      if (chain_q[i].first) begin
        s = i;
        e = 1'b1;
      end
    d = chain_q[s].v;
    for (int i = s + 1; i < chain_q.size(); i++) begin
      case (chain_q[i].op)
        2'd0:    d = d & chain_q[i].v;
        2'd1:    d = d | chain_q[i].v;
        2'd2:    d = d ^ chain_q[i].v;
        default: d = ~(d | chain_q[i].v);
      endcase
    end
    c = chain_q.size() - s;
    if (c > 255) c = 255;
  endtask

  task automatic send_beat(input logic [1:0] op, input logic [N-1:0] v, input bit first, input bit last);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = v; cmd_first = first; cmd_last = last;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (last) cmd_valid = 1'b0;
    chain_q.push_back('{op: op, v: v, first: first});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  // Called right after the closing beat's edge; stall_cycles of backpressure.
  task automatic expect_result(input string tag, input logic [N-1:0] d, input int c, input bit e,
                               input int stall_cycles);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, res_data}, {24'd0, d});
    chk({tag, "_count"}, {24'd0, res_count}, c);
    chk({tag, "_err"},   {31'd0, res_err}, {31'd0, e});
    for (int i = 0; i < stall_cycles; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
      chk({tag, "_hold_data"},  {24'd0, res_data}, {24'd0, d});
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drop_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    chain_q.delete();
  endtask

  task automatic expect_model(input string tag, input int stall_cycles);
    logic [N-1:0] d;
    int c;
    bit e;
    model_result(d, c, e);
    expect_result(tag, d, c, e, stall_cycles);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_operand = '0;
    cmd_first = 1'b0; cmd_last = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_res_data",  {24'd0, res_data}, 32'd0);
    chk("rst_res_count", {24'd0, res_count}, 32'd0);
    chk("rst_res_err",   {31'd0, res_err}, 32'd0);
    chk("idle_ready",    {31'd0, cmd_ready}, 32'd1);

    // Single beat; op ignored on the first beat.
    send_beat(2'b11, 8'hA5, 1, 1);
    expect_result("single", 8'hA5, 1, 0, 0);

    // Back-to-back chain A5 | 0F & 3C ^ FF.
    send_beat(2'b00, 8'hA5, 1, 0);
    send_beat(2'b01, 8'h0F, 0, 0);
    send_beat(2'b00, 8'h3C, 0, 0);
    send_beat(2'b10, 8'hFF, 0, 1);
    expect_result("chain4", 8'hD3, 4, 0, 0);

    // NOR chain.
    send_beat(2'b00, 8'h00, 1, 0);
    send_beat(2'b11, 8'h00, 0, 0);
    send_beat(2'b11, 8'hF0, 0, 1);
    expect_result("nor", 8'h00, 3, 0, 0);

    // Backpressure with cmd_valid held high in RESP.
    send_beat(2'b00, 8'h96, 1, 1);
    @(negedge clk);
    chk("bp_valid", {31'd0, res_valid}, 32'd1);
    cmd_valid = 1'b1; cmd_first = 1'b1; cmd_last = 1'b1; cmd_operand = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_data",  {24'd0, res_data}, 32'h96);
      chk("bp_count", {24'd0, res_count}, 32'd1);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_drop_valid", {31'd0, res_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
    chain_q.delete();

    // Protocol violations.
    send_beat(2'b00, 8'h3C, 0, 1);
    expect_result("nofirst", 8'h3C, 1, 1, 0);
    send_beat(2'b00, 8'h11, 1, 0);
    send_beat(2'b01, 8'h22, 0, 0);
    send_beat(2'b00, 8'h44, 1, 0);
    send_beat(2'b01, 8'h08, 0, 1);
    expect_result("restart", 8'h4C, 2, 1, 0);

    // Reset mid-chain discards the partial chain.
    send_beat(2'b00, 8'h77, 1, 0);
    send_beat(2'b10, 8'h0F, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chain_q.delete();
    send_beat(2'b01, 8'h5A, 1, 1);
    expect_result("post_rst", 8'h5A, 1, 0, 0);

    // Saturating count over a 260-beat chain.
    send_beat(2'($urandom), 8'($urandom), 1, 0);
    for (int i = 1; i < 260; i++)
      send_beat(2'($urandom), 8'($urandom), 0, i == 259);
    expect_model("sat", 0);
    chk("sat_count_abs", {24'd0, res_count}, 32'd255);

    // Random chains with gaps, occasional violations and random backpressure.
    for (int k = 0; k < 40; k++) begin
      int len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        bit first = (i == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
        if (i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_beat(2'($urandom), 8'($urandom), first, i == len - 1);
      end
      expect_model("rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_chain_issuer.md
Name: logic_chain_issuer

Overview:
- Initiator side of the bitwise-logic datapath.
- Accepts a stream of op/operand command beats over a valid/ready handshake and applies them to an internal accumulator (acc <= acc OP operand).
- Returns one result beat per chain over a second valid/ready handshake.
- Sits between the iteration control logic and downstream consumers, giving them a sequenced, backpressured front end to the AND/OR/XOR/NOR op set.

Parameters:
- N, 8, datapath width of operand, accumulator and result.
- CW, 8, width of the beat counter reported with each result; saturates at 2^CW-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command beat present.
- cmd_ready  out  1  block can accept a command beat this cycle.
- cmd_op  in  2  op code: 00 AND, 01 OR, 10 XOR, 11 NOR.
- cmd_operand  in  N  right-hand operand.
- cmd_first  in  1  beat opens a chain; loads acc with cmd_operand and ignores cmd_op.
- cmd_last  in  1  beat closes the chain; result is issued.
- res_valid  out  1  result beat present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  N  final accumulator value of the chain.
- res_count  out  CW  number of beats in the chain, including the first (saturating).
- res_err  out  1  chain had a protocol violation (see Behaviour).

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; acc, count, res_data, res_count = 0; res_valid=0; res_err=0.
  - cmd_ready=0 while rst_n is low.
- A beat transfers when cmd_valid & cmd_ready; a result transfers when res_valid & res_ready.
- cmd_ready = 1 in IDLE and CHAIN, 0 in RESP. It is a combinational decode of state only and has no dependency on cmd_valid.
- States:
  - IDLE, accepted beat:
    - acc <= cmd_operand; count <= 1; err <= ~cmd_first. A missing cmd_first is a violation, but the load still happens.
    - If cmd_last, go to RESP; otherwise go to CHAIN.
  - CHAIN, accepted beat with cmd_first=1 (restart):
    - acc <= cmd_operand; count <= 1; err <= 1 (sticky for this chain).
  - CHAIN, accepted beat with cmd_first=0:
    - acc <= f(op, acc, operand); count <= sat(count+1).
  - CHAIN, transition: if cmd_last on the accepted beat, go to RESP.
  - RESP, on entry:
    - res_valid=1; res_data, res_count, res_err registered from the values updated by the closing beat.
  - RESP, hold: outputs held stable until res_ready. cmd_valid is ignored and nothing changes.
  - RESP, on transfer: res_valid=0 and state=IDLE next cycle. The first new beat can be accepted the cycle after the transfer, which gives a one-cycle bubble.
- Op function f is bitwise over N bits: 00 a&b, 01 a|b, 10 a^b, 11 ~(a|b).
- Latency: result is visible one cycle after the closing beat is accepted.
- Throughput: one beat per cycle within a chain; a chain of k beats occupies k+1 cycles minimum plus the bubble.
- Count saturates at all-ones and never wraps. res_err is not set by saturation.
- Idle cycles between beats inside a chain (cmd_valid=0) are allowed; state and acc are held.
- Reset mid-chain or mid-RESP: the chain is discarded, with no partial result.
- res_data/res_count/res_err are don't-care while res_valid=0, but are required to hold their last values (no X).

Decomposition:
- Shared package logic_pkg:
  - op-code constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11.
  - state encoding constants ST_IDLE, ST_CHAIN, ST_RESP.
- One sub-module, logic_op_eval (parameter N; inputs a, b, op; output r):
  - purely combinational bitwise evaluator used for the acc update.
  - FSM, counter and output registers stay in logic_chain_issuer.

Test Plan:
1. Single beat, first=1 last=1, op=11, operand 8'hA5 -> next cycle res_valid=1, res_data=8'hA5, res_count=1, res_err=0. Op is ignored on the first beat.
2. Chain: A5(first), OR 0F, AND 3C, XOR FF(last), back-to-back -> res_data=8'hD3 (AF, 2C, D3), res_count=4, res_err=0; res_valid one cycle after the last beat.
3. NOR: 00(first), NOR 00, NOR F0(last) -> FF then 00; res_data=8'h00, res_count=3.
4. Backpressure: hold res_ready=0 for 5 cycles in RESP with cmd_valid=1 -> cmd_ready=0 throughout, res_data/res_count stable. After res_ready=1: res_valid=0 next cycle, cmd_ready=1.
5. Violations:
   - IDLE beat 3C with first=0 and last=1 -> res_data=3C, res_err=1.
   - Chain 11(first), OR 22, then 44(first), OR 08(last) -> res_data=4C, res_count=2, res_err=1.
6. Reset: assert rst_n low mid-chain after 2 beats -> res_valid=0 and cmd_ready=0 immediately. After release, chain 5A(first,last) gives res_data=5A, res_count=1, res_err=0. Also run 260 beats with CW=8 -> res_count=255.
